// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment display readback path.
// Segment codes are active-low with bit7 = decimal point (off).
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [5:0] SEG_BLANK_SEL = 6'h3F;

  localparam logic [7:0] SEG_CODE_0 = 8'hC0;
  localparam logic [7:0] SEG_CODE_1 = 8'hF9;
  localparam logic [7:0] SEG_CODE_2 = 8'hA4;
  localparam logic [7:0] SEG_CODE_3 = 8'hB0;
  localparam logic [7:0] SEG_CODE_4 = 8'h99;
  localparam logic [7:0] SEG_CODE_5 = 8'h92;
  localparam logic [7:0] SEG_CODE_6 = 8'h82;
  localparam logic [7:0] SEG_CODE_7 = 8'hF8;
  localparam logic [7:0] SEG_CODE_8 = 8'h80;
  localparam logic [7:0] SEG_CODE_9 = 8'h90;

  // Capture FSM encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] seg_state_t;
  localparam seg_state_t ST_WAIT = 2'd0;
  localparam seg_state_t ST_EVAL = 2'd1;
  localparam seg_state_t ST_HOLD = 2'd2;

  // Number of asserted (low) lines on an active-low select bus.
  function automatic int unsigned low_count(input logic [5:0] sel);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (!sel[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/seg_pattern_to_bcd.sv
// Combinational decode of an active-low 7-segment pattern (g..a) to BCD.
// Any pattern outside the ten digit shapes is flagged invalid.
module seg_pattern_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] bcd,
  output logic       valid
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    bcd   = 4'd0;
    valid = 1'b1;
    case (pattern)
      SEG_CODE_0[6:0]: bcd = 4'd0;
      SEG_CODE_1[6:0]: bcd = 4'd1;
      SEG_CODE_2[6:0]: bcd = 4'd2;
      SEG_CODE_3[6:0]: bcd = 4'd3;
      SEG_CODE_4[6:0]: bcd = 4'd4;
      SEG_CODE_5[6:0]: bcd = 4'd5;
      SEG_CODE_6[6:0]: bcd = 4'd6;
      SEG_CODE_7[6:0]: bcd = 4'd7;
      SEG_CODE_8[6:0]: bcd = 4'd8;
      SEG_CODE_9[6:0]: bcd = 4'd9;
      default:         valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed seven-segment bus: waits for each digit slot
// to settle, decodes it, and publishes a full frame once every slot is seen.
module seg_scan_capture #(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_DIGITS    = seg_pkg::NUM_DIGITS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_DIGITS-1:0]   sel_in,
  input  logic [7:0]              dig_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic                    frame_valid,
  output logic [NUM_DIGITS-1:0]   capture_mask,
  output logic                    pattern_err,
  output logic                    sel_err
);
  import seg_pkg::*;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  logic [NUM_DIGITS-1:0]   sel_r, sel_p;
  logic [7:0]              dig_r, dig_p;
  logic                    changed;
  logic [3:0]              cnt, cnt_next;
  seg_state_t              state, state_next;
  logic [3:0]              bcd;
  logic                    bcd_valid;
  logic                    do_eval;
  logic                    multi_sel;
  logic [NUM_DIGITS-1:0]   hit;
  logic [4*NUM_DIGITS-1:0] work;
  logic                    frame_done;

  // sel_p/dig_p hold the previous cycle's registered inputs; once the counter
  // has settled they are the stable window value, even if the pins move on
  // in the evaluation cycle itself.
  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_r <= SEG_BLANK_SEL;
      dig_r <= '1;
      sel_p <= SEG_BLANK_SEL;
      dig_p <= '1;
    end else begin
      sel_r <= sel_in;
      dig_r <= dig_in;
      sel_p <= sel_r;
      dig_p <= dig_r;
    end
  end

  assign changed = (sel_r != sel_p) || (dig_r != dig_p);

  always_comb begin
    cnt_next = cnt;
    if (changed)            cnt_next = 4'd0;
    else if (cnt != SETTLE) cnt_next = cnt + 4'd1;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT: if (cnt_next == SETTLE) state_next = ST_EVAL;
      ST_EVAL: state_next = changed ? ST_WAIT : ST_HOLD;
      ST_HOLD: if (changed) state_next = ST_WAIT;
      default: state_next = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= 4'd0;
      state <= ST_WAIT;
    end else begin
      cnt   <= cnt_next;
      state <= state_next;
    end
  end

  seg_pattern_to_bcd u_decode (
    .pattern (dig_p[6:0]),
    .bcd     (bcd),
    .valid   (bcd_valid)
  );

  assign do_eval   = (state == ST_EVAL) && (sel_p != SEG_BLANK_SEL);
  assign multi_sel = low_count(sel_p) > 1;
  assign hit       = ~sel_p;

  // Completion is flagged at the capture edge and published one cycle later,
  // so error pulses (EVAL only) can never coincide with frame_valid.
  // NOTE: the working register is an ordinary flop bank and is reset along with
  // the rest so a fresh frame never exposes stale digits from before reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits_out   <= '0;
      frame_valid  <= 1'b0;
      capture_mask <= '0;
      pattern_err  <= 1'b0;
      sel_err      <= 1'b0;
      work         <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
      sel_err     <= 1'b0;
      frame_done  <= 1'b0;
      if (frame_done) begin
        digits_out   <= work;
        frame_valid  <= 1'b1;
        capture_mask <= '0;
      end
      if (do_eval) begin
        if (multi_sel) begin
          sel_err      <= 1'b1;
          capture_mask <= '0;
        end else if (!bcd_valid) begin
          pattern_err  <= 1'b1;
          capture_mask <= '0;
        end else begin
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (hit[k]) work[4*k +: 4] <= bcd;
          end
          capture_mask <= capture_mask | hit;
          frame_done   <= &(capture_mask | hit);
        end
      end
    end
  end

endmodule
